cpu_seq_regfile: RTL
====================

Name: cpu_seq_regfile

Overview:
- Sequencer and operand stage of the 16-bit multi-cycle CPU; sits directly upstream of the ALU and also consumes its result.
- Generates the one-hot 4-phase signal `ph` and owns the PC, the instruction register and the 8-entry register file.
- Drives the ALU inputs `sr1`, `sr2`, `pc`, `ir` and `ph`.
- Performs writeback and PC redirect from the ALU output `alu_q`.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NREG, 8, register count; fixed by the 3-bit register fields.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- run  in  1  phase-advance enable; low freezes all state.
- imem_addr  out  16  instruction address; equals `pc`, combinational.
- imem_data  in  16  instruction word; combinational read of `imem_addr`.
- alu_q  in  16  ALU result.
- ph  out  4  one-hot phase (bit0 fetch, bit1 operand read, bit2 execute, bit3 writeback).
- pc  out  16  program counter.
- ir  out  16  instruction register.
- sr1  out  16  source operand 1 = `rf[ir[10:8]]`, registered.
- sr2  out  16  source operand 2 = `rf[ir[7:5]]`, registered.
- dbg_sel  in  3  debug register select.
- dbg_data  out  16  `rf[dbg_sel]`, combinational.

Behaviour:
- Reset: clock edge with RST=1 sets `ph`=0000, `pc`=RESET_PC, `ir`=0, `sr1`=`sr2`=0, all rf entries=0.
  - RST has priority over everything, including `run` and a mid-instruction phase; the in-flight instruction is discarded and there is no writeback.
- Phase sequencing, `run`=1:
  - `ph`=0000 -> 0001.
  - Otherwise rotate left: 0001->0010->0100->1000->0001.
  - Exactly one phase per cycle; one instruction every 4 cycles.
- `run`=0: `ph`, `pc`, `ir`, `sr1`, `sr2` and rf all hold; no writeback; `dbg_data` stays live.
- Edge actions when `run`=1, selected by the current `ph`:
  - `ph[0]`: `ir` <= `imem_data`; `pc` <= `pc`+1, wrapping FFFF->0000.
  - `ph[1]`: `sr1` <= `rf[ir[10:8]]`; `sr2` <= `rf[ir[7:5]]`.
  - `ph[2]`: no state change; the ALU evaluates.
  - `ph[3]`, writeback: `rf[ir[13:11]]` <= `alu_q` when
    - `ir[15:14]`=00 and `ir[4:0]`=00010 (ADD), or
    - `ir[15:14]`=01 and `ir[10:8]`=000 (LI).
  - `ph[3]`, branch: if `ir[15:14]`=10, `pc` <= `alu_q`. The ALU supplies either the target or the fall-through PC; this block applies no condition.
  - `ph[3]`: all other encodings cause no state change.
- `ph`=0000 (first cycle after reset): no fetch, no read, no writeback.
- r0 is an ordinary writable register (no hardwired zero).
- Read/write hazards: none within one instruction, since the read is in `ph[1]` and the write in `ph[3]`. The next instruction reads at its own `ph[1]`, after the previous writeback has landed.
- `dbg_data` reflects a write in the cycle after the writeback edge.
- `imem_addr` changes only on `pc` updates. Instruction memory must return data combinationally before the `ph[0]` edge.
- All arithmetic is 16-bit modulo; no flags are kept here.

Test Plan:
- Reset mid-instruction: run the program to `ph`=0100 with `pc`=3, assert RST for 1 cycle -> next cycle `ph`=0000, `pc`=0, `ir`=0, `sr1`=`sr2`=0, `dbg_data`=0 for every `dbg_sel`; the cycle after, `ph`=0001.
- Phase and fetch: imem[0]=16'h78CE (LI r7,-50), bench ALU returns sign-extended `ir[7:0]` for LI.
  - -> `ph` sequence 0000,0001,0010,0100,1000,0001.
  - -> `ir`=78CE after the `ph[0]` edge; `pc`=1.
  - -> after the `ph[3]` edge, `rf[7]`=FFCE and `pc` is still 1.
- ADD writeback: r6=0064, r7=FFCE, imem=16'h37C2 (ADD r6,r7,r6), bench ALU = `sr1`+`sr2`.
  - -> after `ph[1]`, `sr1`=FFCE, `sr2`=0064.
  - -> after `ph[3]`, `rf[6]`=0032.
  - -> rf[0..5], rf[7] unchanged.
- Branch redirect:
  - imem[3]=16'h8EFE, `alu_q`=0002 during `ph[3]` -> `pc` goes 4 -> 2; `imem_addr`=0002 next cycle; no rf write.
  - Same with `alu_q`=0004 -> `pc` stays 4.
- Stall: drop `run` for 3 cycles while `ph`=0010 -> `ph`, `pc`, `ir`, `sr1`, `sr2` frozen; raise `run` -> `ph[1]` actions complete exactly once; the total instruction takes 7 cycles.
- No-write encodings: `ir` class 00 with `ir[4:0]`=00011, and class 01 with `ir[10:8]`=001, with `alu_q`=ABCD -> no rf entry changes; `pc` increments normally.

Source files
------------

// File: rtl/cpu_seq_regfile.sv
// cpu_seq_regfile
// Sequencer and operand stage of the 16-bit multi-cycle CPU. It steps a
// one-hot four-phase counter, owns the program counter, the instruction
// register and the 8-entry register file, feeds the ALU and takes the ALU
// result back for register writeback and PC redirect.
//
// Ports
//   CLK        system clock, all state updates on the rising edge
//   RST        synchronous active-high reset, overrides everything
//   run        phase-advance enable; low freezes all state
//   imem_addr  instruction address (always equal to pc)
//   imem_data  instruction word, combinational read of imem_addr
//   alu_q      ALU result used for writeback and branch redirect
//   ph         one-hot phase: bit0 fetch, bit1 read, bit2 execute, bit3 writeback
//   pc         program counter
//   ir         instruction register
//   sr1        registered operand rf[ir[10:8]]
//   sr2        registered operand rf[ir[7:5]]
//   dbg_sel    debug register select
//   dbg_data   rf[dbg_sel], combinational
module cpu_seq_regfile #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          NREG     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        run,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic [15:0] alu_q,
    output logic [3:0]  ph,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [15:0] sr1,
    output logic [15:0] sr2,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    // The phase encoding is the one-hot value seen on the ph port, with an
    // all-zero idle state that only exists for the first cycle after reset.
    typedef enum logic [3:0] {
        PH_IDLE  = 4'b0000,
        PH_FETCH = 4'b0001,
        PH_READ  = 4'b0010,
        PH_EXEC  = 4'b0100,
        PH_WB    = 4'b1000
    } phase_e;

    phase_e      ph_q, ph_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] sr1_q, sr1_d;
    logic [15:0] sr2_q, sr2_d;
    logic [15:0] rf_q [NREG];
    logic        rf_we;
    logic        isAdd;
    logic        isLi;
    logic        isBranch;

    // Instruction classes that matter to this stage. ADD needs its function
    // field to match, LI only writes when its source field is zero; anything
    // else falls through as a no-op at writeback.
    always_comb begin
        isAdd    = (ir_q[15:14] == 2'b00) && (ir_q[4:0] == 5'b00010);
        isLi     = (ir_q[15:14] == 2'b01) && (ir_q[10:8] == 3'b000);
        isBranch = (ir_q[15:14] == 2'b10);
    end

    // Next-state logic. Everything holds by default so that run=0 freezes
    // the whole stage. The branch redirect is unconditional here because the
    // ALU already picked either the target or the fall-through address.
    always_comb begin
        ph_d  = ph_q;
        pc_d  = pc_q;
        ir_d  = ir_q;
        sr1_d = sr1_q;
        sr2_d = sr2_q;
        rf_we = 1'b0;
        if (run) begin
            case (ph_q)
                PH_IDLE: begin
                    ph_d = PH_FETCH;
                end
                PH_FETCH: begin
                    ir_d = imem_data;
                    pc_d = pc_q + 16'd1;
                    ph_d = PH_READ;
                end
                PH_READ: begin
                    sr1_d = rf_q[ir_q[10:8]];
                    sr2_d = rf_q[ir_q[7:5]];
                    ph_d  = PH_EXEC;
                end
                PH_EXEC: begin
                    ph_d = PH_WB;
                end
                PH_WB: begin
                    rf_we = isAdd || isLi;
                    if (isBranch) begin
                        pc_d = alu_q;
                    end
                    ph_d = PH_FETCH;
                end
                default: begin
                    ph_d = PH_IDLE;
                end
            endcase
        end
    end

    // State registers and register file. Reset wins over run and discards
    // whatever instruction was in flight, including any pending writeback.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ph_q  <= PH_IDLE;
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            sr1_q <= '0;
            sr2_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            ph_q  <= ph_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            sr1_q <= sr1_d;
            sr2_q <= sr2_d;
            if (rf_we) begin
                rf_q[ir_q[13:11]] <= alu_q;
            end
        end
    end

    // Output drive. The debug port reads the register file directly so a
    // write becomes visible in the cycle after its writeback edge.
    always_comb begin
        ph        = ph_q;
        pc        = pc_q;
        imem_addr = pc_q;
        ir        = ir_q;
        sr1       = sr1_q;
        sr2       = sr2_q;
        dbg_data  = rf_q[dbg_sel];
    end

endmodule
